// File: rtl/rv_float_wb_ctrl.sv
// Write-back controller for the FP register file: two buffered producer channels,
// round-robin arbitration onto one write port, and a per-register busy scoreboard.
module rv_float_wb_ctrl #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned FLEN     = 32,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                alloc_valid_i,
    input  logic [AW-1:0]       alloc_addr_i,
    output logic                alloc_ready_o,
    input  logic                a_valid_i,
    input  logic [AW-1:0]       a_addr_i,
    input  logic [FLEN-1:0]     a_data_i,
    output logic                a_ready_o,
    input  logic                b_valid_i,
    input  logic [AW-1:0]       b_addr_i,
    input  logic [FLEN-1:0]     b_data_i,
    output logic                b_ready_o,
    output logic [AW-1:0]       rd_addr_o,
    output logic [FLEN-1:0]     rd_data_o,
    output logic                rd_en_o,
    output logic [NUM_REGS-1:0] busy_o,
    output logic                err_o
);

    logic                a_vld_q, a_vld_d, b_vld_q, b_vld_d;
    logic [AW-1:0]       a_addr_q, a_addr_d, b_addr_q, b_addr_d;
    logic [FLEN-1:0]     a_data_q, a_data_d, b_data_q, b_data_d;
    logic                ptr_q, ptr_d; // 0 favours A, 1 favours B on contention
    logic                rd_en_q, rd_en_d;
    logic [AW-1:0]       rd_addr_q, rd_addr_d;
    logic [FLEN-1:0]     rd_data_q, rd_data_d;
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                err_q, err_d;
    logic                gnt_a, gnt_b;

    always_comb begin
        gnt_a = a_vld_q & (~b_vld_q | ~ptr_q);
        gnt_b = b_vld_q & (~a_vld_q | ptr_q);

        alloc_ready_o = ~busy_q[alloc_addr_i];
        a_ready_o     = ~a_vld_q | gnt_a;
        b_ready_o     = ~b_vld_q | gnt_b;

        a_vld_d  = a_vld_q & ~gnt_a;
        a_addr_d = a_addr_q;
        a_data_d = a_data_q;
        if (a_valid_i && a_ready_o) begin
            a_vld_d  = 1'b1;
            a_addr_d = a_addr_i;
            a_data_d = a_data_i;
        end

        b_vld_d  = b_vld_q & ~gnt_b;
        b_addr_d = b_addr_q;
        b_data_d = b_data_q;
        if (b_valid_i && b_ready_o) begin
            b_vld_d  = 1'b1;
            b_addr_d = b_addr_i;
            b_data_d = b_data_i;
        end

        ptr_d     = ptr_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (gnt_a) begin
            ptr_d     = 1'b1;
            rd_en_d   = 1'b1;
            rd_addr_d = a_addr_q;
            rd_data_d = a_data_q;
        end else if (gnt_b) begin
            ptr_d     = 1'b0;
            rd_en_d   = 1'b1;
            rd_addr_d = b_addr_q;
            rd_data_d = b_data_q;
        end

        // Clear applied before set so a same-edge allocation wins.
        busy_d = busy_q;
        err_d  = err_q;
        if (rd_en_q) begin
            err_d             = err_q | ~busy_q[rd_addr_q];
            busy_d[rd_addr_q] = 1'b0;
        end
        if (alloc_valid_i && alloc_ready_o) begin
            busy_d[alloc_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            a_vld_q   <= 1'b0;
            a_addr_q  <= '0;
            a_data_q  <= '0;
            b_vld_q   <= 1'b0;
            b_addr_q  <= '0;
            b_data_q  <= '0;
            ptr_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            busy_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            a_vld_q   <= a_vld_d;
            a_addr_q  <= a_addr_d;
            a_data_q  <= a_data_d;
            b_vld_q   <= b_vld_d;
            b_addr_q  <= b_addr_d;
            b_data_q  <= b_data_d;
            ptr_q     <= ptr_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    assign rd_en_o   = rd_en_q;
    assign rd_addr_o = rd_addr_q;
    assign rd_data_o = rd_data_q;
    assign busy_o    = busy_q;
    assign err_o     = err_q;

endmodule
